// File: rtl/commit_unit_if.sv
// commit_unit_if: writeCommit bus from the reorder buffer (master) to the commit unit (slave).
interface commit_unit_if #(
  parameter int WIDTH = 31,
  parameter int CONTROL = 7,
  parameter int INDEX = 7
);
  logic validCommit;
  logic [WIDTH:0] result;
  logic [WIDTH:0] destCommit;
  logic [3:0] commitInfo;
  logic [CONTROL:0] controlFlow;
  logic [WIDTH:0] targetAddress;
  logic [WIDTH:0] oldPC;
  logic [WIDTH:0] statusSnap;
  logic [INDEX:0] previousIndex;
  modport master (output validCommit, result, destCommit, commitInfo, controlFlow, targetAddress, oldPC, statusSnap, previousIndex);
  modport slave (input validCommit, result, destCommit, commitInfo, controlFlow, targetAddress, oldPC, statusSnap, previousIndex);
endinterface

// File: rtl/commit_unit.sv
// commit_unit: retires writeCommit entries into RF writes, a draining store queue, predictor updates and mispredict flushes.
// Define COMMIT_PERF_EN to add the retired_count/flush_count performance counters.
module commit_unit #(
  parameter int WIDTH = 31,
  parameter int CONTROL = 7,
  parameter int INDEX = 7,
  parameter int REG = 4,
  parameter int SQ_DEPTH = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic clk,
  input  logic reset_n,
  commit_unit_if.slave cb,
  output logic rf_we,
  output logic [REG:0] rf_addr,
  output logic [WIDTH:0] rf_data,
  output logic mem_req,
  output logic [WIDTH:0] mem_addr,
  output logic [WIDTH:0] mem_data,
  input  logic mem_ack,
  output logic sq_full,
  output logic sq_overflow,
  output logic pht_we,
  output logic [INDEX:0] pht_index,
  output logic [1:0] pht_state,
  output logic btb_we,
  output logic [WIDTH:0] btb_pc,
  output logic [WIDTH:0] btb_target,
  output logic flush,
  output logic freeze,
  output logic redirect_valid,
  output logic [WIDTH:0] redirect_pc,
  output logic status_restore,
  output logic [WIDTH:0] status_snap
`ifdef COMMIT_PERF_EN
  ,
  output logic [31:0] retired_count,
  output logic [15:0] flush_count
`endif
);
  localparam int PW = $clog2(SQ_DEPTH);
  localparam int CW = $clog2(SQ_DEPTH + 1);
  typedef enum logic [1:0] {IDLE, FLUSH, SETTLE} state_t;
  state_t state, nextState;
  logic [7:0] settleCnt;
  logic [WIDTH:0] sqAddr [SQ_DEPTH];
  logic [WIDTH:0] sqData [SQ_DEPTH];
  logic [PW-1:0] rdPtr, wrPtr;
  logic [CW-1:0] count;
  logic isControl, accept, trigger, push, pop, doPush, unused;
  // controlFlow, MSB down: isControl, state[1:0], writeBTB, takenBranch, mispredict, misdirect, rsv
  assign isControl = cb.controlFlow[CONTROL];
  assign accept = cb.validCommit && state == IDLE;
  assign trigger = accept && isControl && (cb.controlFlow[CONTROL-5] || cb.controlFlow[CONTROL-6]);
  assign push = accept && cb.commitInfo[2];
  assign pop = mem_req && mem_ack;
  assign doPush = push && (!sq_full || pop);
  assign sq_full = count == CW'(SQ_DEPTH);
  assign mem_req = count != '0;
  assign mem_addr = sqAddr[rdPtr];
  assign mem_data = sqData[rdPtr];
  assign flush = state == FLUSH;
  assign redirect_valid = flush;
  assign status_restore = flush;
  assign freeze = state != IDLE;
  assign unused = &{1'b0, cb.commitInfo[1], cb.controlFlow[CONTROL-7:0]};
  always_ff @(posedge clk) state <= !reset_n ? IDLE : nextState;
  always_comb begin
    nextState = state;
    case (state)
      IDLE: nextState = trigger ? FLUSH : IDLE;
      FLUSH: nextState = SETTLE;
      SETTLE: nextState = settleCnt == '0 ? IDLE : SETTLE;
      default: nextState = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rf_we <= 1'b0;
      rf_addr <= '0;
      rf_data <= '0;
      pht_we <= 1'b0;
      pht_index <= '0;
      pht_state <= '0;
      btb_we <= 1'b0;
      btb_pc <= '0;
      btb_target <= '0;
      redirect_pc <= '0;
      status_snap <= '0;
      settleCnt <= '0;
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
      sq_overflow <= 1'b0;
      for (int i = 0; i < SQ_DEPTH; i++) begin
        sqAddr[i] <= '0;
        sqData[i] <= '0;
      end
    end else begin
      rf_we <= accept && cb.commitInfo[3] && cb.destCommit[REG:0] != '0;
      if (accept && cb.commitInfo[3]) begin
        rf_addr <= cb.destCommit[REG:0];
        rf_data <= cb.result;
      end
      pht_we <= accept && isControl && cb.commitInfo[0];
      if (accept && isControl && cb.commitInfo[0]) begin
        pht_index <= cb.previousIndex;
        pht_state <= cb.controlFlow[CONTROL-1:CONTROL-2];
      end
      btb_we <= accept && isControl && cb.controlFlow[CONTROL-3];
      if (accept && isControl && cb.controlFlow[CONTROL-3]) begin
        btb_pc <= cb.oldPC;
        btb_target <= cb.targetAddress;
      end
      if (trigger) begin
        redirect_pc <= cb.controlFlow[CONTROL-4] ? cb.targetAddress : cb.oldPC + (WIDTH+1)'(4);
        status_snap <= cb.statusSnap;
      end
      settleCnt <= state == FLUSH ? 8'(FLUSH_CYCLES - 1) : settleCnt - 8'(state == SETTLE);
      // A push into a full queue is only legal when the head leaves in the same cycle
      if (doPush) begin
        sqAddr[wrPtr] <= cb.destCommit;
        sqData[wrPtr] <= cb.result;
        wrPtr <= wrPtr + PW'(1);
      end
      if (pop) rdPtr <= rdPtr + PW'(1);
      if (doPush != pop) count <= doPush ? count + CW'(1) : count - CW'(1);
      if (push && sq_full && !pop) sq_overflow <= 1'b1;
    end
  end
`ifdef COMMIT_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      retired_count <= '0;
      flush_count <= '0;
    end else begin
      retired_count <= retired_count + 32'(accept);
      flush_count <= flush_count + 16'(trigger);
    end
  end
`endif
endmodule
